// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI command sequencer: decodes a captured 6-byte frame, then drives the R1 / token / block handshake.
// Optional SD_CMD_CRC_CHECK_EN adds a combinational CRC7 check of the frame during DECODE.
module sd_cmd_sequencer #(
    parameter int COMMAND_SIZE         = 6,
    parameter int MEMORY_SIZE_IN_BYTES = 64,
    parameter int NCR_CYCLES           = 8,
    localparam int SIZE_W              = (MEMORY_SIZE_IN_BYTES > 1) ? $clog2(MEMORY_SIZE_IN_BYTES) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              transfer_i,
    input  logic [COMMAND_SIZE-1:0][7:0]      cmd_i,
    input  logic                              done_i,
    output logic                              start_o,
    output logic                              op_o,
    output logic [SIZE_W-1:0]                 size_o,
    output logic                              data_sel_o,
    output logic [7:0]                        resp_o,
    output logic [5:0]                        cmd_idx_o,
    output logic [31:0]                       arg_o,
    output logic                              busy_o,
    output logic                              ovr_o
);

    localparam logic [SIZE_W-1:0] BLOCK_LAST = SIZE_W'(MEMORY_SIZE_IN_BYTES - 1);
    localparam logic [7:0]        NCR_LOAD   = 8'(NCR_CYCLES - 1);
    localparam logic [7:0]        TOKEN_BYTE = 8'hFE;
    localparam logic [7:0]        RESP_IDLE  = 8'hFF;

    typedef enum logic [3:0] {
        IDLE,
        DECODE,
        NCR,
        RESP,
        RESP_WAIT,
        TOKEN,
        TOKEN_WAIT,
        DATA,
        DATA_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [5:0]         cmd_idx_q, cmd_idx_d;
    logic [31:0]        arg_q, arg_d;
    logic               idle_q, idle_d;
    logic               app_q, app_d;
    logic [7:0]         r1_q, r1_d;
    logic               pend_tx_q, pend_tx_d;
    logic               pend_rx_q, pend_rx_d;
    logic               op_q, op_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic               data_sel_q, data_sel_d;
    logic [7:0]         resp_q, resp_d;
    logic               ovr_q, ovr_d;
    logic               crc_err;
    logic               illegal;

`ifdef SD_CMD_CRC_CHECK_EN
    logic [1:0]         frame_hi_q, frame_hi_d;
    logic [6:0]         crc_q, crc_d;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    // Check runs on the latched frame so DECODE does not depend on cmd_i staying stable.
    assign crc_err = (crc7({frame_hi_q, cmd_idx_q, arg_q}) != crc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_hi_q <= 2'd0;
            crc_q      <= 7'd0;
        end else begin
            frame_hi_q <= frame_hi_d;
            crc_q      <= crc_d;
        end
    end
`else
    logic unused_frame_bits;
    assign unused_frame_bits = ^{cmd_i[0][7:6], cmd_i[COMMAND_SIZE-1]};
    assign crc_err           = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_idx_d  = cmd_idx_q;
        arg_d      = arg_q;
        idle_d     = idle_q;
        app_d      = app_q;
        r1_d       = r1_q;
        pend_tx_d  = pend_tx_q;
        pend_rx_d  = pend_rx_q;
        op_d       = op_q;
        size_d     = size_q;
        data_sel_d = data_sel_q;
        resp_d     = resp_q;
        ovr_d      = ovr_q;
        illegal    = 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
        frame_hi_d = frame_hi_q;
        crc_d      = crc_q;
`endif

        case (state_q)
            IDLE: begin
                if (transfer_i) begin
                    cmd_idx_d = cmd_i[0][5:0];
                    arg_d     = {cmd_i[1], cmd_i[2], cmd_i[3], cmd_i[4]};
`ifdef SD_CMD_CRC_CHECK_EN
                    frame_hi_d = cmd_i[0][7:6];
                    crc_d      = cmd_i[COMMAND_SIZE-1][7:1];
`endif
                    state_d   = DECODE;
                end
            end

            DECODE: begin
                pend_tx_d = 1'b0;
                pend_rx_d = 1'b0;
                // A corrupted frame leaves idle/app untouched and is never executed.
                if (!crc_err) begin
                    app_d = 1'b0;
                    case (cmd_idx_q)
                        6'd0: begin
                            idle_d = 1'b1;
                        end
                        6'd55: begin
                            app_d = 1'b1;
                        end
                        6'd41: begin
                            if (app_q) begin
                                idle_d = 1'b0;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                        6'd16: begin
                            illegal = 1'b0;
                        end
                        6'd17: begin
                            if (idle_q) begin
                                illegal = 1'b1;
                            end else begin
                                pend_tx_d = 1'b1;
                            end
                        end
                        6'd24: begin
                            if (idle_q) begin
                                illegal = 1'b1;
                            end else begin
                                pend_rx_d = 1'b1;
                            end
                        end
                        default: begin
                            illegal = 1'b1;
                        end
                    endcase
                end
                r1_d    = {4'b0000, crc_err, illegal, 1'b0, idle_d};
                cnt_d   = NCR_LOAD;
                state_d = NCR;
            end

            NCR: begin
                if (cnt_q == 8'd0) begin
                    op_d       = 1'b1;
                    size_d     = '0;
                    data_sel_d = 1'b0;
                    resp_d     = r1_q;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            RESP: begin
                state_d = RESP_WAIT;
            end

            RESP_WAIT: begin
                if (done_i) begin
                    if (pend_tx_q) begin
                        op_d       = 1'b1;
                        size_d     = '0;
                        data_sel_d = 1'b0;
                        resp_d     = TOKEN_BYTE;
                        state_d    = TOKEN;
                    end else if (pend_rx_q) begin
                        op_d       = 1'b0;
                        size_d     = BLOCK_LAST;
                        data_sel_d = 1'b1;
                        resp_d     = RESP_IDLE;
                        state_d    = DATA;
                    end else begin
                        op_d       = 1'b0;
                        size_d     = '0;
                        data_sel_d = 1'b0;
                        resp_d     = RESP_IDLE;
                        state_d    = IDLE;
                    end
                end
            end

            TOKEN: begin
                state_d = TOKEN_WAIT;
            end

            TOKEN_WAIT: begin
                if (done_i) begin
                    op_d       = 1'b1;
                    size_d     = BLOCK_LAST;
                    data_sel_d = 1'b1;
                    resp_d     = RESP_IDLE;
                    state_d    = DATA;
                end
            end

            DATA: begin
                state_d = DATA_WAIT;
            end

            DATA_WAIT: begin
                if (done_i) begin
                    op_d       = 1'b0;
                    size_d     = '0;
                    data_sel_d = 1'b0;
                    resp_d     = RESP_IDLE;
                    pend_tx_d  = 1'b0;
                    pend_rx_d  = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (transfer_i && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            cmd_idx_q  <= 6'd0;
            arg_q      <= 32'd0;
            idle_q     <= 1'b1;
            app_q      <= 1'b0;
            r1_q       <= 8'd0;
            pend_tx_q  <= 1'b0;
            pend_rx_q  <= 1'b0;
            op_q       <= 1'b0;
            size_q     <= '0;
            data_sel_q <= 1'b0;
            resp_q     <= RESP_IDLE;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_idx_q  <= cmd_idx_d;
            arg_q      <= arg_d;
            idle_q     <= idle_d;
            app_q      <= app_d;
            r1_q       <= r1_d;
            pend_tx_q  <= pend_tx_d;
            pend_rx_q  <= pend_rx_d;
            op_q       <= op_d;
            size_q     <= size_d;
            data_sel_q <= data_sel_d;
            resp_q     <= resp_d;
            ovr_q      <= ovr_d;
        end
    end

    assign start_o    = (state_q == RESP) || (state_q == TOKEN) || (state_q == DATA);
    assign busy_o     = (state_q != IDLE);
    assign op_o       = op_q;
    assign size_o     = size_q;
    assign data_sel_o = data_sel_q;
    assign resp_o     = resp_q;
    assign cmd_idx_o  = cmd_idx_q;
    assign arg_o      = arg_q;
    assign ovr_o      = ovr_q;

endmodule
